mt_seed_ctrl: RTL and testbench
===============================

# mt_seed_ctrl

Hardware initiator for the `mersenne_twister` core. It expands a single 32-bit seed into the 624-word MT19937 initial state and streams that state into the core over its `load_value`/`value` port. It then issues `gen_rv` requests and delivers each `rv` on a valid/ready output stream. It sits between a host/seed source and the twister core, replacing the bench-driven loading and request sequence.

## Interface
- `W`, 32: word width
- `N`, 624: state words to load
- `INIT_MULT`, 32'd1812433253: MT19937 init multiplier
- `clk` in 1: sole clock, rising edge
- `n_rst` in 1: asynchronous, active-low reset
- `seed_valid` in 1: seed request
- `seed` in W: seed value, sampled with `seed_valid && seed_ready`
- `seed_ready` out 1: controller can accept a seed
- `init_done` out 1: all N words loaded; core is generating
- `out_valid` out 1: `out_data` holds a random value
- `out_ready` in 1: consumer accepts `out_data`
- `out_data` out W: random value
- `load_value` out 1: one-cycle pulse; core stores `value`
- `value` out W: state word to core
- `gen_rv` out 1: one-cycle pulse; core advances
- `rv` in W: core output, stable from the cycle after `gen_rv`

## Operation
- The FSM has five states: IDLE, LOAD, GAP, REQ, WAIT.
- IDLE:
  - `seed_ready`=1.
  - On handshake: `word`←seed, `idx`←0, `init_done`←0, go to LOAD.
- LOAD:
  - `load_value`=1, `value`=`word`. Go to GAP.
- GAP:
  - `load_value`=0.
  - `word`←(INIT_MULT·(word ^ (word>>30)) + idx+1) mod 2^W, using the low W bits of the product only.
  - `idx`←idx+1.
  - If idx was N-1: `init_done`←1, go to REQ. Otherwise go to LOAD.
  - The multiply is combinational within GAP; one registered stage is allowed provided GAP stays one cycle.
- REQ:
  - Entered only if the output buffer has a free entry; otherwise wait in REQ with `gen_rv`=0.
  - When free: `gen_rv`=1 for exactly one cycle, go to WAIT.
- WAIT:
  - Capture `rv` into the output buffer at the end of the cycle, go to REQ.
- Output: `out_valid` holds, and `out_data` is stable, until `out_ready`.
- Reseed: `seed_ready`=1 in IDLE, and in REQ when no `gen_rv` is in flight.
  - A reseed in REQ flushes the output buffer (`out_valid`=0 next cycle), clears `init_done` and enters LOAD.
- `seed_ready`=0 in LOAD, GAP and WAIT.
- Simultaneous `out_ready` pop and WAIT capture into a full single-entry buffer cannot occur, because REQ requires a free entry.

## Timing
- Reset value of every output is 0: `seed_ready` and the rest are forced to 0 during reset. `seed_ready` rises the first cycle after `n_rst` deasserts (IDLE).
- Reset mid-load or mid-request returns the FSM to IDLE and empties the buffer. The core must be reset together with this block.
- Seed accepted at edge t: `load_value` high in cycle t+1, then every second cycle.
- Load totals 2·N = 1248 cycles. The last `load_value` is in cycle t+1247, and `init_done`=1 from cycle t+1249.
- `gen_rv` is high in cycle r. `rv` is captured at the end of cycle r+1, and `out_valid` is high in cycle r+2.
- Minimum `gen_rv` spacing is 2 cycles.
- Steady-state throughput with `out_ready`=1 is one value per 2 cycles. The first value appears 2 cycles after the first `gen_rv`.

## Configuration
- `MT_PREFETCH_EN` defined:
  - The output buffer is 2 entries (FIFO).
  - REQ issues `gen_rv` while entry 0 is still waiting for `out_ready`.
  - Values are delivered in generation order.
- `MT_PREFETCH_EN` undefined: the buffer is a single register, and no `gen_rv` is issued while `out_valid`=1 and `out_ready`=0.
- Both builds must produce an identical value sequence; only stall behaviour differs.

## Structure
- Package `mt_pkg`: `W`, `N`, `MT_INIT_MULT`, FSM state enum `mt_ctrl_state_t`, index width `$clog2(N)`.
- Sub-module `mt_out_buffer`:
  - 1 or 2 entry valid/ready buffer, depth selected by `MT_PREFETCH_EN`.
  - Ports: push, data in, full, pop-handshake, `out_valid`/`out_data`, flush.
- Top-level contents: the FSM, index counter and init arithmetic.

## Test plan
- Reset release then seed=0:
  - `value` sequence starts 0x00000000, 0x00000001, 0x6C078967.
  - Exactly 624 `load_value` pulses, all in alternating cycles.
- Seed=5489 with the real `mersenne_twister` and `out_ready`=1:
  - `value`[1]=0x4D98EE96.
  - First `out_data`=0xD091BB5C.
  - 50000 outputs match the software model file.
- Backpressure: `out_ready`=0 for 20 cycles after the first value.
  - Without the macro: exactly 1 `gen_rv` during the stall.
  - With the macro: exactly 2 `gen_rv` during the stall.
  - In both builds `out_data` stays stable and no values are lost or duplicated.
- Reseed in REQ with `out_valid`=1:
  - The buffer is flushed next cycle.
  - `init_done` drops.
  - The new load starts 1 cycle after the handshake.
  - The first output matches the new seed.
- `n_rst` asserted at load word 300:
  - All outputs read 0 immediately.
  - After release the FSM is in IDLE with `seed_ready`=1.
  - A fresh seed=5489 yields 0xD091BB5C first.
- `seed_valid` held during LOAD/GAP: not accepted (`seed_ready`=0), and the load sequence is unaffected.

Source files
------------

// File: rtl/mt_pkg.sv
// Shared types and constants for the MT19937 seed controller.
// Holds the word/state sizes, init multiplier, FSM states and seed-expansion step.
package mt_pkg;

  localparam int              W            = 32;
  localparam int              N            = 624;
  localparam int              IDX_W        = $clog2(N);
  localparam logic [W-1:0]    MT_INIT_MULT = 32'd1812433253;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_REQ,
    ST_WAIT
  } mt_ctrl_state_t;

  // One step of the MT19937 seed expansion; only the low W bits of the product matter.
  function automatic logic [W-1:0] mt_init_next(input logic [W-1:0]     word,
                                                input logic [IDX_W-1:0] idx);
    logic [W-1:0] mixed;
    mixed = word ^ (word >> 30);
    return (MT_INIT_MULT * mixed) + W'(idx) + W'(1);
  endfunction

endpackage

// File: rtl/mt_seed_ctrl_if.sv
// Host-side bundle of the seed controller: seed request stream, init status and
// the valid/ready random-value output stream.
interface mt_seed_ctrl_if;

  logic                 seed_valid;
  logic [mt_pkg::W-1:0] seed;
  logic                 seed_ready;
  logic                 init_done;
  logic                 out_valid;
  logic                 out_ready;
  logic [mt_pkg::W-1:0] out_data;

  modport slave (
    input  seed_valid, seed, out_ready,
    output seed_ready, init_done, out_valid, out_data
  );

  modport master (
    output seed_valid, seed, out_ready,
    input  seed_ready, init_done, out_valid, out_data
  );

endinterface

// File: rtl/mt_out_buffer.sv
// Valid/ready output buffer for generated values: one register by default,
// a 2-entry in-order FIFO when MT_PREFETCH_EN is defined.
module mt_out_buffer
  import mt_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         out_ready,
  output logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

`ifdef MT_PREFETCH_EN
  logic [W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic         valid0_q, valid0_d, valid1_q, valid1_d;

  assign pop       = valid0_q && out_ready;
  assign full      = valid1_q;
  assign out_valid = valid0_q;
  assign out_data  = data0_q;

  // Entry 0 is always the oldest value; a pop shifts entry 1 down.
  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    if (flush) begin
      valid0_d = 1'b0;
      valid1_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b01: begin
          data0_d  = data1_q;
          valid0_d = valid1_q;
          valid1_d = 1'b0;
        end
        2'b10: begin
          if (!valid0_q) begin
            data0_d  = push_data;
            valid0_d = 1'b1;
          end else begin
            data1_d  = push_data;
            valid1_d = 1'b1;
          end
        end
        2'b11: begin
          if (valid1_q) begin
            data0_d = data1_q;
            data1_d = push_data;
          end else begin
            data0_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: data registers are reset too, because out_data is a visible output that must read 0 in reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end
`else
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  assign pop       = valid_q && out_ready;
  assign full      = valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // The controller only pushes when the register is empty or being popped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      data_d  = push_data;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
`endif

endmodule

// File: rtl/mt_seed_ctrl.sv
// Seeds a mersenne_twister core: expands one seed into N state words, loads them,
// then requests values into a valid/ready stream (buffer depth set by MT_PREFETCH_EN).
module mt_seed_ctrl
  import mt_pkg::*;
(
  input  logic          clk,
  input  logic          n_rst,
  mt_seed_ctrl_if.slave bus,
  output logic          load_value,
  output logic [W-1:0]  value,
  output logic          gen_rv,
  input  logic [W-1:0]  rv
);

  mt_ctrl_state_t   state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             run_q, run_d;

  logic seed_hs;
  logic buf_push, buf_flush, buf_full, buf_pop, buf_free;

  // run_q holds seed_ready low through reset and the first cycle after it.
  assign bus.seed_ready = run_q && ((state_q == ST_IDLE) || (state_q == ST_REQ));
  assign seed_hs        = bus.seed_valid && bus.seed_ready;
  assign buf_free       = !buf_full || buf_pop;
  assign value          = word_q;
  assign bus.init_done  = init_done_q;
  assign run_d          = 1'b1;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    load_value  = 1'b0;
    gen_rv      = 1'b0;
    buf_push    = 1'b0;
    buf_flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seed_hs) begin
          word_d      = bus.seed;
          idx_d       = '0;
          init_done_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_value = 1'b1;
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        word_d = mt_init_next(word_q, idx_q);
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          init_done_d = 1'b1;
          state_d     = ST_REQ;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_REQ: begin
        // A reseed takes priority over issuing the next request.
        if (seed_hs) begin
          buf_flush   = 1'b1;
          word_d      = bus.seed;
          idx_d       = '0;
          init_done_d = 1'b0;
          state_d     = ST_LOAD;
        end else if (buf_free) begin
          gen_rv  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        buf_push = 1'b1;
        state_d  = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      run_q       <= run_d;
    end
  end

  mt_out_buffer u_out_buffer (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (rv),
    .full      (buf_full),
    .out_ready (bus.out_ready),
    .pop       (buf_pop),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data)
  );

endmodule

// File: tb/tb_mt_seed_ctrl.sv
// Directed bench for mt_seed_ctrl with a behavioural MT19937 core attached;
// expected values are the published MT19937 figures for seeds 0 and 5489.
module tb_mt_seed_ctrl;

`ifdef MT_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        load_value;
  logic        gen_rv;
  logic [31:0] value;
  logic [31:0] rv;

  mt_seed_ctrl_if bus_if ();

  mt_seed_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus_if),
    .load_value (load_value),
    .value      (value),
    .gen_rv     (gen_rv),
    .rv         (rv)
  );

  always #5 clk = ~clk;

  // Behavioural twister core: sequential loads, per-request incremental twist.
  logic [31:0] mt [624];
  int          lptr;
  int          gidx;
  logic [31:0] nxt_word;

  function automatic logic [31:0] twist(input logic [31:0] cur, nxt, far);
    logic [31:0] y;
    y = {cur[31], nxt[30:0]};
    return far ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
  endfunction

  function automatic logic [31:0] temper(input logic [31:0] x);
    x = x ^ (x >> 11);
    x = x ^ ((x << 7) & 32'h9d2c_5680);
    x = x ^ ((x << 15) & 32'hefc6_0000);
    x = x ^ (x >> 18);
    return x;
  endfunction

  assign nxt_word = twist(mt[gidx], mt[(gidx + 1) % 624], mt[(gidx + 397) % 624]);

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lptr <= 0;
      gidx <= 0;
      rv   <= '0;
    end else if (load_value) begin
      mt[lptr] <= value;
      lptr     <= (lptr == 623) ? 0 : lptr + 1;
      gidx     <= 0;
    end else if (gen_rv) begin
      mt[gidx] <= nxt_word;
      rv       <= temper(nxt_word);
      gidx     <= (gidx == 623) ? 0 : gidx + 1;
    end
  end

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          load_cnt = 0;
  int          gen_cnt = 0;
  int          stab_err = 0;
  logic [31:0] load_val [4096];
  int          load_cyc [4096];
  logic [31:0] outs [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (load_value) begin
      if (load_cnt < 4096) begin
        load_val[load_cnt] = value;
        load_cyc[load_cnt] = cyc;
      end
      load_cnt++;
    end
    if (gen_rv) gen_cnt++;
    if (bus_if.out_valid && bus_if.out_ready) outs.push_back(bus_if.out_data);
    if (prev_stall && (!bus_if.out_valid || bus_if.out_data !== prev_data)) stab_err++;
    prev_stall = n_rst && bus_if.out_valid && !bus_if.out_ready;
    prev_data  = bus_if.out_data;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_out [5];

  initial begin
    int base, k, n, bad, gaps, g0, s0, q0;
    exp_out[0] = 32'hD091_BB5C;
    exp_out[1] = 32'h22AE_9EF6;
    exp_out[2] = 32'hE7E1_FAEE;
    exp_out[3] = 32'hD5C3_1F79;
    exp_out[4] = 32'h2082_352C;

    n_rst             = 1'b0;
    bus_if.seed_valid = 1'b0;
    bus_if.seed       = '0;
    bus_if.out_ready  = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_seed_ready", bus_if.seed_ready, 0);
    check("rst_ctrl", {load_value, gen_rv, bus_if.out_valid, bus_if.init_done}, 0);
    check("rst_value", value, 0);
    check("rst_out_data", bus_if.out_data, 0);
    n_rst = 1'b1;
    check("release_cycle_seed_ready", bus_if.seed_ready, 0);
    step();
    check("idle_seed_ready", bus_if.seed_ready, 1);

    // Seed 0, with seed_valid held (different seed) through the early load
    bus_if.seed       = 32'h0;
    bus_if.seed_valid = 1'b1;
    base = load_cnt;
    step();
    check("load_starts_next_cycle", load_value, 1);
    bus_if.seed = 32'hDEAD_BEEF;
    bad = 0;
    k   = 1;
    while (!bus_if.init_done && k < 1400) begin
      if (k < 200 && bus_if.seed_ready) bad++;
      if (k == 200) bus_if.seed_valid = 1'b0;
      step();
      k++;
    end
    check("held_seed_not_ready", bad, 0);
    check("init_done_cycle", k, 1249);
    check("seed0_load_pulses", load_cnt - base, 624);
    check("seed0_value0", load_val[base], 32'h0000_0000);
    check("seed0_value1", load_val[base + 1], 32'h0000_0001);
    check("seed0_value2", load_val[base + 2], 32'h6C07_8967);
    gaps = 0;
    for (int i = 1; i < 624; i++)
      if (load_cyc[base + i] - load_cyc[base + i - 1] != 2) gaps++;
    check("seed0_load_spacing", gaps, 0);
    check("seed0_last_load_offset", load_cyc[base + 623] - load_cyc[base], 1246);

    // First value with out_ready low, then hold
    n = 0;
    while (!bus_if.out_valid && n < 5) begin
      step();
      n++;
    end
    check("first_value_latency", n, 2);
    g0 = gen_cnt;
    repeat (6) step();
    check("seed0_stall_gen", gen_cnt - g0, PF ? 1 : 0);
    check("req_seed_ready", bus_if.seed_ready, 1);
    check("seed0_out_held", bus_if.out_valid, 1);

    // Reseed in REQ with a value pending
    bus_if.seed       = 32'd5489;
    bus_if.seed_valid = 1'b1;
    base = load_cnt;
    step();
    bus_if.seed_valid = 1'b0;
    check("reseed_flush", bus_if.out_valid, 0);
    check("reseed_init_done_drop", bus_if.init_done, 0);
    check("reseed_load_start", load_value, 1);
    k = 1;
    while (!bus_if.init_done && k < 1400) begin
      step();
      k++;
    end
    check("reseed_init_done_cycle", k, 1249);
    check("s5489_load_pulses", load_cnt - base, 624);
    check("s5489_value0", load_val[base], 32'd5489);
    check("s5489_value1", load_val[base + 1], 32'h4D98_EE96);

    // Backpressure after the first value is taken
    bus_if.out_ready = 1'b1;
    q0 = outs.size();
    step();
    step();
    check("s5489_first_valid", bus_if.out_valid, 1);
    check("s5489_first_data", bus_if.out_data, exp_out[0]);
    g0 = gen_cnt;
    s0 = stab_err;
    step();
    bus_if.out_ready = 1'b0;
    repeat (20) step();
    check("stall_gen_count", gen_cnt - g0, PF ? 2 : 1);
    check("stall_out_valid", bus_if.out_valid, 1);
    check("stall_out_data", bus_if.out_data, exp_out[1]);
    check("stall_stability", stab_err - s0, 0);
    bus_if.out_ready = 1'b1;
    n = 0;
    while (outs.size() - q0 < 5 && n < 100) begin
      step();
      n++;
    end
    check("s5489_out_count", (outs.size() - q0 >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (q0 + i < outs.size()) check($sformatf("s5489_out%0d", i), outs[q0 + i], exp_out[i]);
    g0 = gen_cnt;
    repeat (10) step();
    check("throughput_10_cycles", gen_cnt - g0, 5);

    // Reset in the middle of a load
    bus_if.seed       = 32'h1234_5678;
    bus_if.seed_valid = 1'b1;
    n = 0;
    while (!load_value && n < 10) begin
      step();
      n++;
    end
    bus_if.seed_valid = 1'b0;
    check("reseed3_accepted", load_value, 1);
    base = load_cnt;
    n = 0;
    while (load_cnt - base < 300 && n < 1000) begin
      step();
      n++;
    end
    check("reached_word_300", load_cnt - base, 300);
    n_rst = 1'b0;
    #1;
    check("midrst_ctrl",
          {bus_if.seed_ready, load_value, gen_rv, bus_if.out_valid, bus_if.init_done}, 0);
    check("midrst_value", value, 0);
    check("midrst_out_data", bus_if.out_data, 0);
    step();
    n_rst = 1'b1;
    step();
    check("midrst_idle_ready", bus_if.seed_ready, 1);
    check("midrst_idle_no_load", load_value, 0);

    bus_if.seed       = 32'd5489;
    bus_if.seed_valid = 1'b1;
    q0 = outs.size();
    step();
    bus_if.seed_valid = 1'b0;
    n = 0;
    while (outs.size() == q0 && n < 1400) begin
      step();
      n++;
    end
    check("fresh_out_arrived", (outs.size() > q0), 1);
    if (outs.size() > q0) check("fresh_first_out", outs[q0], exp_out[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
